// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional leading-zero flags are enabled by defining BIN2BCD_LZ_BLANK_EN.
module bin2bcd_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [11:0]      out,
  output logic [2:0]       lz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [WIDTH-1:0]  bin_reg, bin_next;
  logic [11:0]       scratch_reg, scratch_next;
  logic [11:0]       out_reg, out_next;
  logic              done_reg, done_next;
  logic [11:0]       adj;
  logic [WIDTH+11:0] shifted;

  // Any digit >= 5 gets +3 so that the following left shift carries into the next digit.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                              scratch_reg[gi*4 +: 4] + 4'd3 :
                              scratch_reg[gi*4 +: 4];
    end
  endgenerate

  assign shifted = {adj, bin_reg} << 1;

`ifdef BIN2BCD_LZ_BLANK_EN
  // Ones digit is never blanked, so only the hundreds/tens flags need storage.
  logic [1:0] lz_reg, lz_next;
`endif

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bin_next     = bin_reg;
    scratch_next = scratch_reg;
    out_next     = out_reg;
    done_next    = 1'b0;
`ifdef BIN2BCD_LZ_BLANK_EN
    lz_next      = lz_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          bin_next     = in;
          scratch_next = '0;
          cnt_next     = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_next = shifted[WIDTH +: 12];
        bin_next     = shifted[WIDTH-1:0];
        cnt_next     = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
          out_next   = shifted[WIDTH +: 12];
          done_next  = 1'b1;
          state_next = IDLE;
`ifdef BIN2BCD_LZ_BLANK_EN
          lz_next[1] = (shifted[WIDTH+8 +: 4] == 4'd0);
          lz_next[0] = (shifted[WIDTH+8 +: 4] == 4'd0) && (shifted[WIDTH+4 +: 4] == 4'd0);
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bin_reg     <= '0;
      scratch_reg <= '0;
      out_reg     <= '0;
      done_reg    <= 1'b0;
`ifdef BIN2BCD_LZ_BLANK_EN
      lz_reg      <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bin_reg     <= bin_next;
      scratch_reg <= scratch_next;
      out_reg     <= out_next;
      done_reg    <= done_next;
`ifdef BIN2BCD_LZ_BLANK_EN
      lz_reg      <= lz_next;
`endif
    end
  end

  assign busy = (state_reg == SHIFT);
  assign done = done_reg;
  assign out  = out_reg;

`ifdef BIN2BCD_LZ_BLANK_EN
  assign lz = {lz_reg, 1'b0};
`else
  assign lz = 3'b000;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: expected results queued at stimulus time,
// popped and compared whenever the DUT pulses done.
module tb_bin2bcd_seq;

  localparam int W = 8;

  typedef struct {
    logic [11:0] out;
    logic [2:0]  lz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] in_drv;
  logic         busy;
  logic         done;
  logic [11:0]  out;
  logic [2:0]   lz;

  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;
  exp_t exp_q[$];

  bin2bcd_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in_drv),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .lz    (lz)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int v);
    exp_t e;
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    e.out = {h[3:0], t[3:0], o[3:0]};
`ifdef BIN2BCD_LZ_BLANK_EN
    e.lz = {(h == 0), (h == 0 && t == 0), 1'b0};
`else
    e.lz = 3'b000;
`endif
    return e;
  endfunction

  // Scoreboard side: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!(done === 1'b1 && busy === 1'b1)) else begin
        failures++;
        $error("FAIL done_busy_excl observed done=%b busy=%b expected not both 1", done, busy);
      end
      if (done === 1'b1) begin
        exp_t e;
        done_count++;
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_done observed out=%h expected no done pulse", out);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (out === e.out) else begin
            failures++;
            $error("FAIL out observed=%h expected=%h", out, e.out);
          end
          checks++;
          assert (lz === e.lz) else begin
            failures++;
            $error("FAIL lz observed=%b expected=%b", lz, e.lz);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {11'd0, done}, 12'd1);
  endtask

  task automatic run_conv(input int v, input string tag);
    @(negedge clk);
    in_drv = W'(v);
    start  = 1'b1;
    exp_q.push_back(model(v));
    @(negedge clk);
    start  = 1'b0;
    in_drv = W'($urandom);
    wait_done(tag);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    rst_n  = 1'b0;
    start  = 1'b0;
    in_drv = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {11'd0, busy}, 12'd0);
    chk("rst_done", {11'd0, done}, 12'd0);
    chk("rst_out",  out,           12'h000);
    chk("rst_lz",   {9'd0, lz},    12'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 255: busy for W cycles, done in the cycle after edge W
    in_drv = 8'd255;
    start  = 1'b1;
    exp_q.push_back(model(255));
    @(negedge clk);
    start  = 1'b0;
    in_drv = 8'd0;
    for (int i = 0; i < W; i++) begin
      chk("lat_busy", {11'd0, busy}, 12'd1);
      chk("lat_nodone", {11'd0, done}, 12'd0);
      @(negedge clk);
    end
    chk("lat_done", {11'd0, done}, 12'd1);
    chk("lat_out",  out, 12'h255);
    @(negedge clk);
    chk("done_pulse", {11'd0, done}, 12'd0);
    chk("out_hold", out, 12'h255);

    run_conv(0,  "conv_0");
    chk("out_0", out, 12'h000);
    run_conv(7,  "conv_7");
    run_conv(99, "conv_99");
    chk("out_99_hold", out, 12'h099);

    // 128 with start re-pulsed (in=1) during cycles 3..5: ignored
    dc0 = done_count;
    @(negedge clk);
    in_drv = 8'd128;
    start  = 1'b1;
    exp_q.push_back(model(128));
    @(negedge clk);
    start  = 1'b0;
    in_drv = 8'd0;
    @(negedge clk);
    @(negedge clk);
    start  = 1'b1;
    in_drv = 8'd1;
    repeat (3) @(negedge clk);
    start  = 1'b0;
    in_drv = 8'd0;
    wait_done("conv_128");
    repeat (15) @(negedge clk);
    chk("single_done", 12'(done_count - dc0), 12'd1);
    chk("no_queue_busy", {11'd0, busy}, 12'd0);
    chk("out_128_hold", out, 12'h128);

    // Reset at cycle 4 of a conversion aborts it
    @(negedge clk);
    in_drv = 8'd200;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {11'd0, busy}, 12'd0);
    chk("abort_out",  out, 12'h000);
    chk("abort_done", {11'd0, done}, 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_out_hold", out, 12'h000);
    run_conv(42, "conv_42");
    chk("out_42", out, 12'h042);

    // Start held high: back-to-back conversions of 0..255
    start = 1'b1;
    for (int v = 0; v < 256; v++) begin
      in_drv = W'(v);
      exp_q.push_back(model(v));
      @(negedge clk);
      in_drv = W'($urandom);
      repeat (W) @(negedge clk);
      chk("stream_done", {11'd0, done}, 12'd1);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("queue_empty", 12'(exp_q.size()), 12'd0);
    chk("final_out", out, 12'h255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: WIDTH, 8, binary input width; legal range 4..9, so the result always fits 3 BCD digits (max 511).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 in  input  WIDTH  unsigned binary operand; sampled on the accepting edge only.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when out is updated.
REQ-008 out  output  12  registered BCD result: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-009 lz  output  3  leading-zero flags, bit2 hundreds, bit1 tens, bit0 ones; see Configuration.

Function
REQ-010 FSM states SHALL be IDLE and SHIFT only.
REQ-011 In IDLE with start=1, the edge SHALL capture in into a shift register, clear the 12-bit BCD scratch, set cnt=0, and enter SHIFT.
REQ-012 In IDLE with start=0, state, out, lz and scratch SHALL hold.
REQ-013 Each SHIFT edge SHALL first adjust every scratch digit (digit 5..12 -> digit+3; digit 0..4 unchanged), then shift {scratch, binary} left by one bit, and increment cnt.
REQ-014 Adjust SHALL be pure 4-bit combinational logic; digit values 13..15 cannot occur for legal WIDTH.
REQ-015 On the SHIFT edge with cnt==WIDTH-1, the block SHALL load the post-shift scratch into out, assert done for the following cycle, and return to IDLE.
REQ-016 Latency: with start accepted at edge 0, done=1 and out valid in the cycle after edge WIDTH (9 cycles for WIDTH=8).
REQ-017 busy SHALL be 1 exactly while state==SHIFT; done and busy SHALL never both be 1.
REQ-018 start while busy=1 SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-019 start during the done cycle SHALL be accepted (state is IDLE), giving back-to-back throughput of one result per WIDTH+1 cycles.
REQ-020 out and lz SHALL hold their last value until the next done; in changes after acceptance SHALL not affect the result.

Reset
REQ-021 With rst_n=0 asynchronously: state=IDLE, cnt=0, busy=0, done=0, out=12'h000, lz=3'b000, scratch=0.
REQ-022 Reset during SHIFT SHALL abort the conversion with no done pulse; the first start after rst_n rises SHALL convert normally.

Configuration
REQ-023 Macro BIN2BCD_LZ_BLANK_EN defined: lz SHALL be registered together with out.
REQ-024 With the macro, lz[2] = (hundreds==0); lz[1] = (hundreds==0 and tens==0); lz[0] = 0 always, so the ones digit is never blanked.
REQ-025 Macro BIN2BCD_LZ_BLANK_EN undefined: lz SHALL be constant 3'b000, with no extra registers.

Verification
REQ-026 WIDTH=8, in=8'd255, start pulse -> busy for 8 cycles, then done=1 with out=12'h255 in the cycle after edge 8.
REQ-027 in=0 -> out=12'h000; with the macro lz=3'b110, without it lz=3'b000.
REQ-028 in=8'd7 -> out=12'h007, lz=3'b110 (macro on); in=8'd99 -> out=12'h099, lz=3'b100 (macro on).
REQ-029 start reasserted with in=8'd1 at cycles 3..5 of a conversion of 8'd128 -> single done with out=12'h128; no second done.
REQ-030 rst_n pulsed low at cycle 4 of a conversion -> busy=0, out=12'h000 immediately, no done; next start with in=8'd42 -> out=12'h042.
REQ-031 start held high continuously with in stepping 0..255 -> done every 9 cycles, each out equal to the decimal of its captured in; exhaustive compare against a model.
